// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends a byte as one 11-bit frame (start, 8 data LSB first, parity, stop) with a one-entry holding buffer.
// Build option: define PARITY_ODD_EN for odd parity; the default build sends even parity.
module serial_frame_tx #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic       SYNCED_CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       SDATA,
    output logic       BUSY,
    output logic       FRAME_DONE
);
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned GAP_CNT_W = 4;
    localparam int unsigned SEL_W     = 3;
    localparam logic [BIT_CNT_W-1:0] STOP_IDX   = BIT_CNT_W'(10);
    localparam logic [BIT_CNT_W-1:0] PARITY_IDX = BIT_CNT_W'(9);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA  = BIT_CNT_W'(8);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'(IDLE_GAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0]     buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  sdata_d;
    logic                  frame_done_d;
    logic                  busy_d;
    logic                  accept;

    function automatic logic parity_of(input logic [DATA_W-1:0] b);
`ifdef PARITY_ODD_EN
        parity_of = ~(^b);
`else
        parity_of = ^b;
`endif
    endfunction

    // Line level for bit position idx of a frame carrying byte b.
    function automatic logic frame_bit(input logic [DATA_W-1:0] b, input logic [BIT_CNT_W-1:0] idx);
        logic [SEL_W-1:0] sel;
        sel = SEL_W'(idx - BIT_CNT_W'(1));
        if (idx == '0)
            frame_bit = 1'b0;
        else if (idx <= LAST_DATA)
            frame_bit = b[sel];
        else if (idx == PARITY_IDX)
            frame_bit = parity_of(b);
        else
            frame_bit = 1'b1;
    endfunction

    // TX_READY is the registered image of an empty buffer, so accept never collides with a drain.
    assign accept = TX_VALID & TX_READY;

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        shreg_d      = shreg_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        sdata_d      = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    shreg_d    = buf_q;
                    buf_full_d = 1'b0;
                    sdata_d    = 1'b0;
                end else if (accept) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = TX_DATA;
                    sdata_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != STOP_IDX) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    sdata_d   = frame_bit(shreg_q, bit_cnt_d);
                end else if (IDLE_GAP != 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (buf_full_q) begin
                    bit_cnt_d  = '0;
                    shreg_d    = buf_q;
                    buf_full_d = 1'b0;
                    sdata_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q > GAP_CNT_W'(1)) begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end else if (buf_full_q) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    shreg_d    = buf_q;
                    buf_full_d = 1'b0;
                    sdata_d    = 1'b0;
                end else begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accepts outside the IDLE bypass land in the holding buffer.
        if (accept && (state_q != IDLE)) begin
            buf_d      = TX_DATA;
            buf_full_d = 1'b1;
        end

        frame_done_d = (state_d == SHIFT) && (bit_cnt_d == STOP_IDX);
        busy_d       = (state_d != IDLE) || buf_full_d;
    end

    // State and output registers; reset is synchronous.
    always_ff @(posedge SYNCED_CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            SDATA      <= 1'b1;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            TX_READY   <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            SDATA      <= sdata_d;
            BUSY       <= busy_d;
            FRAME_DONE <= frame_done_d;
            TX_READY   <= !buf_full_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two lanes (IDLE_GAP 0 and 2) driven with directed and random traffic,
// each checked every cycle against a frame/timing scoreboard.
`timescale 1ns/1ps
module tb_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        int         acc;
        int         start;
    } rec_t;

    // Expected line level at position n of the frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int n);
        logic        par;
        logic [10:0] fr;
`ifdef PARITY_ODD_EN
        par = ~(^b);
`else
        par = ^b;
`endif
        fr = {1'b1, par, b, 1'b0};
        return fr[n];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int GAP = 2 * g;

        logic       rst;
        logic       valid;
        logic       ready;
        logic       sdata;
        logic       busy;
        logic       fdone;
        logic [7:0] data;

        int   cyc        = 0;
        bit   done       = 1'b0;
        bit   checking   = 1'b0;
        int   last_start = -1000;
        rec_t q[$];

        logic e_sd, e_fd, e_busy, e_rdy;

        serial_frame_tx #(.IDLE_GAP(GAP)) dut (
            .SYNCED_CLK (clk),
            .RST        (rst),
            .TX_DATA    (data),
            .TX_VALID   (valid),
            .TX_READY   (ready),
            .SDATA      (sdata),
            .BUSY       (busy),
            .FRAME_DONE (fdone)
        );

        task automatic check(input string name, input logic act, input logic exp);
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL gap%0d cycle %0d %s: got %b expected %b", GAP, cyc, name, act, exp);
            end
        endtask

        // Called just after an edge: drives inputs for the next edge and records any accept.
        task automatic drive(input logic v, input logic [7:0] d, output bit acc);
            int a, lf, s;
            valid = v;
            data  = d;
            acc   = 1'b0;
            if (v && ready === 1'b1 && rst === 1'b1) begin
                acc = 1'b1;
                a   = cyc + 1;
                lf  = last_start + 11 + GAP;
                if (a < lf)       s = lf;
                else if (a == lf) s = a + 1;
                else              s = a;
                last_start = s;
                q.push_back('{d, a, s});
            end
            @(posedge clk);
            #2;
        endtask

        task automatic idle(input int n);
            bit acc;
            repeat (n) drive(1'b0, 8'h00, acc);
        endtask

        task automatic do_reset(input int n);
            rst        = 1'b0;
            valid      = 1'b0;
            last_start = -1000;
            repeat (n) begin
                @(posedge clk);
                #2;
                checking = 1'b1;
            end
            rst = 1'b1;
        endtask

        // Edge bookkeeping: cycle count and model flush on reset.
        always @(posedge clk) begin
            cyc++;
            if (rst === 1'b0) q.delete();
        end

        // Per-cycle comparison against the scoreboard.
        always @(negedge clk) begin
            if (checking) begin
                while (q.size() > 0 && q[0].start + 11 + GAP <= cyc) void'(q.pop_front());
                e_sd   = 1'b1;
                e_fd   = 1'b0;
                e_busy = 1'b0;
                e_rdy  = 1'b1;
                foreach (q[i]) begin
                    if (q[i].start <= cyc && cyc <= q[i].start + 10) begin
                        e_sd = exp_bit(q[i].data, cyc - q[i].start);
                        e_fd = (cyc == q[i].start + 10);
                    end
                    if (q[i].acc <= cyc && cyc < q[i].start + 11 + GAP) e_busy = 1'b1;
                    if (q[i].acc <= cyc && cyc < q[i].start) e_rdy = 1'b0;
                end
                check("SDATA", sdata, e_sd);
                check("FRAME_DONE", fdone, e_fd);
                check("BUSY", busy, e_busy);
                check("TX_READY", ready, e_rdy);
            end
        end

        initial begin
            bit acc;
            bit got;
            int pct;
            rst   = 1'b0;
            valid = 1'b0;
            data  = 8'h00;
            do_reset(2);

            // Single frame of 0xA5.
            drive(1'b1, 8'hA5, acc);
            idle(16);

            // 0x01 then 0x80 buffered, then 0x3C held until the buffer drains.
            drive(1'b1, 8'h01, acc);
            drive(1'b1, 8'h80, acc);
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) drive(1'b1, 8'h3C, got);
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL gap%0d hold_3c: got not-accepted expected accepted within 40 cycles", GAP);
            end
            idle(40);

            // Random traffic with varying offered load.
            for (int p = 0; p < 6; p++) begin
                pct = 20 + 15 * p;
                for (int i = 0; i < 250; i++)
                    drive(($urandom_range(0, 99) < pct), 8'($urandom), acc);
            end
            idle(40);

            // Reset five cycles into a frame with a byte buffered, then a clean 0x00 frame.
            drive(1'b1, 8'h55, acc);
            drive(1'b1, 8'hAA, acc);
            idle(3);
            do_reset(1);
            idle(2);
            drive(1'b1, 8'h00, acc);
            idle(16);

            // Odd/even parity extremes.
            drive(1'b1, 8'h00, acc);
            drive(1'b1, 8'hFF, acc);
            idle(40);
            done = 1'b1;
        end
    end

    initial begin
        wait (lane[0].done && lane[1].done);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
